// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: streams NWORDS words, LS word first,
// through one shared external WORD_W-bit adder and chains the carry between passes.
module mp_add_seq #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned NWORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [WORD_W*NWORDS-1:0]   req_a,
  input  logic [WORD_W*NWORDS-1:0]   req_b,
  input  logic                       req_cin,
  input  logic                       req_sub,
  output logic [WORD_W-1:0]          add_a,
  output logic [WORD_W-1:0]          add_b,
  output logic                       add_cin,
  input  logic [WORD_W-1:0]          add_s,
  input  logic                       add_cout,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WORD_W*NWORDS-1:0]   res_sum,
  output logic                       res_cout,
  output logic                       res_ovf
);

  localparam int unsigned W     = WORD_W * NWORDS;
  localparam int unsigned SW    = W - WORD_W;
  localparam int unsigned IDX_W = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [W-1:0]      a_sh, b_sh;
  logic [SW-1:0]     sum_q;
  logic              carry_q;
  logic              a_sign_q, b_sign_q;
  logic              accept, last;

  assign last = (idx_q == LAST_IDX);

  // Operand shifters present the current word in their low bits and drain to zero,
  // so the adder inputs read back as zero whenever no operation is running.
  assign add_a   = a_sh[WORD_W-1:0];
  assign add_b   = b_sh[WORD_W-1:0];
  assign add_cin = carry_q;

  // Next-state decode
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Handshake flags track the next state so they equal a pure decode of state_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      res_valid <= 1'b0;
    end else begin
      req_ready <= (state_d == IDLE);
      res_valid <= (state_d == DONE);
    end
  end

  // Word datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_ovf  <= 1'b0;
    end else if (accept) begin
      idx_q    <= '0;
      a_sh     <= req_a;
      b_sh     <= req_sub ? ~req_b : req_b;
      carry_q  <= req_sub ? 1'b1 : req_cin;
      a_sign_q <= req_a[W-1];
      b_sign_q <= req_sub ? ~req_b[W-1] : req_b[W-1];
    end else if (state_q == RUN) begin
      a_sh <= a_sh >> WORD_W;
      b_sh <= b_sh >> WORD_W;
      if (last) begin
        idx_q    <= '0;
        carry_q  <= 1'b0;
        res_sum  <= {add_s, sum_q};
        res_cout <= add_cout;
        res_ovf  <= (a_sign_q == b_sign_q) & (add_s[WORD_W-1] != a_sign_q);
      end else begin
        idx_q   <= idx_q + IDX_W'(1);
        carry_q <= add_cout;
        sum_q   <= (sum_q >> WORD_W) | (SW'(add_s) << (SW - WORD_W));
      end
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq: models the external 16-bit adder and scores results
// against a whole-width reference computed when each request is driven.
module tb_mp_add_seq;

  localparam int unsigned WW = 16;
  localparam int unsigned NW = 4;
  localparam int unsigned W  = WW * NW;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic          clk, rst_n;
  logic          req_valid, req_ready, req_cin, req_sub;
  logic [W-1:0]  req_a, req_b;
  logic [WW-1:0] add_a, add_b, add_s;
  logic          add_cin, add_cout;
  logic          res_valid, res_ready, res_cout, res_ovf;
  logic [W-1:0]  res_sum;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  mp_add_seq #(.WORD_W(WW), .NWORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sub(req_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf)
  );

  // Shared external ripple adder
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{WW{1'b0}}, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t         r;
    logic [W-1:0] bb;
    logic [W:0]   t;
    bb     = sub ? ~b : b;
    t      = {1'b0, a} + {1'b0, bb} + (W+1)'(sub ? 1'b1 : cin);
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    return r;
  endfunction

  // Drives one request, scrambles req_* after acceptance, and waits for res_valid.
  // lat counts rising edges from the accept edge (inclusive) to the one raising res_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub,
                        output int lat, output logic [NW-1:0] cins);
    int guard;
    @(negedge clk);
    req_a = a; req_b = b; req_cin = cin; req_sub = sub; req_valid = 1'b1;
    sb.push_back(model(a, b, cin, sub));
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    req_cin = ~cin; req_sub = ~sub;
    lat  = 1;
    cins = '0;
    while (!res_valid && lat < 20) begin
      if (lat <= NW) cins = {add_cin, cins[NW-1:1]};
      @(negedge clk);
      lat++;
    end
    if (!res_valid) lat = -1;
  endtask

  task automatic take();
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_cin = 1'b0; req_sub = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready, res_valid} !== 2'b10) $display("FAIL reset_hs: got ready/valid=%b want 10", {req_ready, res_valid});
    else n_pass++;
    n_checks++;
    if ({res_sum, res_cout, res_ovf} !== '0) $display("FAIL reset_res: got sum=%h cout=%b ovf=%b want 0", res_sum, res_cout, res_ovf);
    else n_pass++;
    n_checks++;
    if ({add_a, add_b, add_cin} !== '0) $display("FAIL reset_add: got a=%h b=%h cin=%b want 0", add_a, add_b, add_cin);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_add();
    int lat; logic [NW-1:0] cins; exp_t e;
    run_op(64'h1, 64'h10, 1'b0, 1'b0, lat, cins);
    n_checks++;
    if (lat != NW + 1) $display("FAIL basic_latency: got %0d want %0d", lat, NW + 1);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({res_sum, res_cout, res_ovf} !== {64'h11, 1'b0, 1'b0} || e.sum !== 64'h11)
      $display("FAIL basic_result: got sum=%h cout=%b ovf=%b want sum=%h cout=0 ovf=0", res_sum, res_cout, res_ovf, e.sum);
    else n_pass++;
    n_checks++;
    if ({add_a, add_b, add_cin, req_ready} !== '0) $display("FAIL done_idle_adder: got a=%h b=%h cin=%b ready=%b want 0", add_a, add_b, add_cin, req_ready);
    else n_pass++;
    take();
    n_checks++;
    if ({req_ready, res_valid, res_sum} !== {2'b10, 64'h11}) $display("FAIL after_take: got ready=%b valid=%b sum=%h want 1 0 %h", req_ready, res_valid, res_sum, 64'h11);
    else n_pass++;
  endtask

  task automatic test_carry_chain();
    int lat; logic [NW-1:0] cins; exp_t e;
    run_op(64'hFFFF, 64'h1, 1'b0, 1'b0, lat, cins);
    n_checks++;
    if (cins !== 4'b0010) $display("FAIL carry_trace: got add_cin per word=%b want 0010", cins);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({res_sum, res_cout, res_ovf} !== {e.sum, e.cout, e.ovf}) $display("FAIL carry_word0: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", res_sum, res_cout, res_ovf, e.sum, e.cout, e.ovf);
    else n_pass++;
    take();
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, lat, cins);
    e = sb.pop_front();
    n_checks++;
    if ({res_sum, res_cout, res_ovf} !== {64'h0, 1'b1, 1'b0} || cins !== 4'b1111)
      $display("FAIL carry_full: got sum=%h cout=%b ovf=%b cins=%b want sum=0 cout=1 ovf=0 cins=1111", res_sum, res_cout, res_ovf, cins);
    else n_pass++;
    take();
  endtask

  task automatic test_overflow();
    int lat; logic [NW-1:0] cins; exp_t e;
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat, cins);
    e = sb.pop_front();
    n_checks++;
    if ({res_sum, res_cout, res_ovf} !== {64'h8000_0000_0000_0000, 1'b0, 1'b1} || e.ovf !== 1'b1)
      $display("FAIL ovf_pos: got sum=%h cout=%b ovf=%b want sum=8000000000000000 cout=0 ovf=1", res_sum, res_cout, res_ovf);
    else n_pass++;
    take();
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, lat, cins);
    e = sb.pop_front();
    n_checks++;
    if ({res_sum, res_cout, res_ovf} !== {e.sum, e.cout, e.ovf}) $display("FAIL ovf_neg: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", res_sum, res_cout, res_ovf, e.sum, e.cout, e.ovf);
    else n_pass++;
    take();
  endtask

  task automatic test_subtract();
    int lat; logic [NW-1:0] cins; exp_t e;
    run_op(64'h0, 64'h1, 1'b1, 1'b1, lat, cins);
    e = sb.pop_front();
    n_checks++;
    if ({res_sum, res_cout, res_ovf} !== {64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0} || e.sum !== 64'hFFFF_FFFF_FFFF_FFFF)
      $display("FAIL sub_borrow: got sum=%h cout=%b ovf=%b want sum=ffffffffffffffff cout=0 ovf=0", res_sum, res_cout, res_ovf);
    else n_pass++;
    take();
    for (int c = 0; c < 2; c++) begin
      run_op(64'h8ABC_0000_0000_0000, 64'h1, c[0], 1'b1, lat, cins);
      e = sb.pop_front();
      n_checks++;
      if ({res_sum, res_cout} !== {64'h8ABB_FFFF_FFFF_FFFF, 1'b1} || res_ovf !== e.ovf)
        $display("FAIL sub_cin%0d: got sum=%h cout=%b ovf=%b want sum=8abbffffffffffff cout=1 ovf=%b", c, res_sum, res_cout, res_ovf, e.ovf);
      else n_pass++;
      take();
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [NW-1:0] cins; exp_t e1, e2;
    logic [W-1:0] a2, b2;
    a2 = 64'h0123_4567_89AB_CDEF;
    b2 = 64'hFEDC_BA98_7654_3211;
    run_op(64'h1234_0000_FFFF_0001, 64'h0000_FFFF_0001_FFFF, 1'b1, 1'b0, lat, cins);
    e1 = sb.pop_front();
    req_a = a2; req_b = b2; req_cin = 1'b0; req_sub = 1'b0; req_valid = 1'b1;
    sb.push_back(model(a2, b2, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({res_valid, req_ready, res_sum, res_cout, res_ovf} !== {2'b10, e1.sum, e1.cout, e1.ovf})
        $display("FAIL hold_%0d: got valid=%b ready=%b sum=%h cout=%b want 1 0 %h %b", i, res_valid, req_ready, res_sum, res_cout, e1.sum, e1.cout);
      else n_pass++;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_checks++;
    if ({req_ready, res_valid, res_sum} !== {2'b10, e1.sum}) $display("FAIL reenter_idle: got ready=%b valid=%b sum=%h want 1 0 %h", req_ready, res_valid, res_sum, e1.sum);
    else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    req_a = '0; req_b = '0;
    lat = 1;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != NW + 1 || !res_valid) $display("FAIL b2b_latency: got %0d edges valid=%b want %0d", lat, res_valid, NW + 1);
    else n_pass++;
    e2 = sb.pop_front();
    n_checks++;
    if ({res_sum, res_cout, res_ovf} !== {e2.sum, e2.cout, e2.ovf}) $display("FAIL b2b_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", res_sum, res_cout, res_ovf, e2.sum, e2.cout, e2.ovf);
    else n_pass++;
    take();
  endtask

  task automatic test_reset_midrun();
    int lat; logic [NW-1:0] cins; exp_t e; logic seen;
    @(negedge clk);
    req_a = 64'hAAAA_AAAA_AAAA_AAAA; req_b = 64'h5555_5555_5555_5555;
    req_cin = 1'b0; req_sub = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({add_a, add_b} !== {16'hAAAA, 16'h5555}) $display("FAIL word2_drive: got a=%h b=%h want aaaa 5555", add_a, add_b);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, res_valid, res_sum, res_cout, res_ovf, add_a, add_b, add_cin} !== {1'b1, {(W+2*WW+4){1'b0}}})
      $display("FAIL abort_reset: got ready=%b valid=%b sum=%h a=%h b=%h cin=%b want 1 0 0 0 0 0", req_ready, res_valid, res_sum, add_a, add_b, add_cin);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL abort_no_result: got res_valid seen=%b want 0", seen);
    else n_pass++;
    run_op(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b0, lat, cins);
    e = sb.pop_front();
    n_checks++;
    if ({res_sum, res_cout, res_ovf} !== {64'hFFFF_FFFF_FFFF_FFFF, 1'b0, e.ovf} || lat != NW + 1)
      $display("FAIL reissue: got sum=%h cout=%b lat=%0d want sum=ffffffffffffffff cout=0 lat=%0d", res_sum, res_cout, lat, NW + 1);
    else n_pass++;
    take();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_chain();
    test_overflow();
    test_subtract();
    test_back_to_back();
    test_reset_midrun();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
Multi-precision add/subtract sequencer. It computes NWORDS×WORD_W-bit sums by time-multiplexing one external WORD_W-bit ripple adder (adder_16bit), one word per cycle, LS word first. Carry is propagated between passes. Operands arrive on a valid/ready request channel; results leave on a valid/ready response channel. It sits between the arithmetic command source and the shared adder instance.

Parameters:
WORD_W, 16, width of the external adder and of one operand word
NWORDS, 4, number of words per operand; total operand width W = WORD_W*NWORDS (>=2)

Ports:
clk  in  1  single clock, rising-edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_a  in  W  operand A
req_b  in  W  operand B
req_cin  in  1  carry-in (ignored when req_sub=1)
req_sub  in  1  1 = A-B, 0 = A+B+cin
add_a  out  WORD_W  to adder a
add_b  out  WORD_W  to adder b
add_cin  out  1  to adder cin
add_s  in  WORD_W  from adder s (combinational)
add_cout  in  1  from adder cout
res_valid  out  1  result present
res_ready  in  1  consumer accepts result
res_sum  out  W  result
res_cout  out  1  final carry (sub: 1 = no borrow)
res_ovf  out  1  signed overflow

Behaviour:
- States: IDLE, RUN, DONE. Word index idx counts 0..NWORDS-1.
- Reset (async, rst_n=0): state=IDLE, idx=0, carry reg=0, operand/sum regs=0. res_valid=0, res_sum=0, res_cout=0, res_ovf=0, add_a/add_b/add_cin=0. req_ready=1, since it is decoded from IDLE.
- req_ready=1 only in IDLE. res_valid=1 only in DONE. Both are decoded from state with no combinational path from req_valid/res_ready.
- IDLE: on req_valid & req_ready, capture A, B' = req_sub ? ~req_b : req_b, carry = req_sub ? 1 : req_cin, and a_sign/b'_sign. Then idx=0 and go to RUN.
- RUN, each cycle:
  - add_a = A[idx], add_b = B'[idx], add_cin = carry reg.
  - At the edge: sum[idx] <= add_s, carry <= add_cout.
  - If idx==NWORDS-1: latch res_cout = add_cout and res_ovf = (a_sign==b'_sign) & (add_s[MSB]!=a_sign), then go to DONE. Otherwise idx++.
- add_* outputs are 0 outside RUN.
- Latency: the accept edge, then NWORDS RUN cycles. res_valid rises on the edge after the last word, i.e. NWORDS+1 cycles after acceptance. Throughput: one op per NWORDS+2 cycles minimum.
- DONE: res_sum/res_cout/res_ovf are held stable while res_valid=1 & res_ready=0 (backpressure of any length). On res_valid & res_ready, go to IDLE. res_valid falls on the next cycle and res_sum keeps its value.
- A new request cannot be accepted in the same cycle a result is taken (req_ready=0 in DONE).
- req_valid while busy is ignored; the source must hold it until req_ready.
- Changes to req_* after acceptance have no effect.
- Reset mid-RUN or mid-DONE aborts the operation: the partial result is discarded and no res_valid is produced.
- Wrap-around: the sum is modulo 2^W; overflow is reported only via res_cout/res_ovf.

Test Plan:
1. A=0x0000_0000_0000_0001, B=0x0000_0000_0000_0010, cin=0, add -> res_sum=0x0000_0000_0000_0011, cout=0, ovf=0. res_valid first high exactly 5 cycles after the accept edge.
2. A=0x0000_0000_0000_FFFF, B=0x0000_0000_0000_0001 -> sum=0x0000_0000_0001_0000; add_cin=1 observed on word 1. Then A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> sum=0, cout=1, ovf=0.
3. Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0. A=0x8000_0000_0000_0000, B=0x8000_0000_0000_0000 -> sum=0, cout=1, ovf=1.
4. Subtract: A=0, B=1, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0 (borrow), ovf=0. A=0x8ABC_0000_0000_0000, B=0x0000_0000_0000_0001, sub=1 -> sum=0x8ABB_FFFF_FFFF_FFFF, cout=1. Verify that req_cin=1 is ignored in subtract mode.
5. Backpressure: hold res_ready=0 for 3 cycles in DONE -> res_valid, res_sum and res_cout stay stable and req_ready stays 0. Keep req_valid asserted throughout -> the next request is accepted only once IDLE is re-entered.
6. Reset: assert rst_n=0 during word 2 of A=0xAAAA_AAAA_AAAA_AAAA + B=0x5555_5555_5555_5555 -> all outputs go 0 immediately and req_ready=1. After release, no res_valid appears. Re-issuing the same op -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0.
